axi_clint_xbar: RTL and testbench
=================================

// Module: axi_clint_xbar
// PURPOSE
//   1-master/2-slave AXI4 router placed directly upstream of the CLINT. Accepts the core's memory AXI port and steers each
//   transaction by address: CLINT window to slave 0, everything else to the SoC bus on slave 1. Single outstanding read and
//   single outstanding write; holds request signals stable to the chosen slave until its response completes.
// PARAMETERS
//   CLINT_BASE  32'h0200_0000  base of CLINT window (aligned to CLINT_SIZE)
//   CLINT_SIZE  32'h0001_0000  window size in bytes, power of two
// PORTS
//   clk           in   1   clock
//   rst           in   1   reset, asynchronous, active-high
//   m_ar{addr,valid,id,len,size,burst}    in  32/1/4/8/3/2  upstream AR; m_arready out 1
//   m_r{data,resp,valid,last,id}          out 32/2/1/1/4    upstream R;  m_rready in 1
//   m_aw{addr,valid,id,len,size,burst}    in  32/1/4/8/3/2  upstream AW; m_awready out 1
//   m_w{data,strb,valid,last}             in  32/4/1/1      upstream W;  m_wready out 1
//   m_b{resp,valid,id}                    out 2/1/4         upstream B;  m_bready in 1
//   s0_* / s1_*   mirror of m_* with directions reversed   slave 0 = CLINT, slave 1 = SoC
// BEHAVIOUR
//   Decode: sel = ((addr & ~(CLINT_SIZE-1)) == CLINT_BASE) ? 0 : 1; computed on the captured address.
//   Read FSM R_IDLE -> R_REQ -> R_RESP -> R_IDLE:
//   - R_IDLE: m_arready=1; on m_arvalid&m_arready latch all AR fields + sel, go R_REQ (1-cycle latency to slave).
//   - R_REQ: s{sel}_arvalid=1 from registers; other slave arvalid=0; on s{sel}_arready go R_RESP.
//   - R_RESP: s{sel}_araddr/id/len/size/burst stay driven from latch (CLINT samples araddr after AR fire);
//     m_r* = s{sel}_r* combinationally, s{sel}_rready = m_rready; non-selected rready=0;
//     on rvalid&rready&rlast go R_IDLE; m_arready=0 for whole R_REQ/R_RESP.
//   Write FSM W_IDLE -> W_REQ -> W_RESP -> W_IDLE:
//   - W_IDLE: m_awready and m_wready independently 1 until their channel captured; AW and W may arrive in any order or
//     same cycle; each ready drops after its capture; go W_REQ when both held.
//   - W_REQ: s{sel}_awvalid and s{sel}_wvalid both asserted in the same cycle (CLINT needs both together); each drops
//     after its own handshake; go W_RESP when both done (same cycle allowed).
//   - W_RESP: m_b* = s{sel}_b*, s{sel}_bready = m_bready; on bvalid&bready go W_IDLE.
//   Read and write FSMs independent; concurrent read and write to the same slave permitted.
//   Only single-beat writes supported: m_wlast forwarded as-is; read bursts forwarded beat by beat until rlast.
//   Response fields (resp, data, id) passed through unmodified, incl. SLVERR from CLINT.
//   Non-selected slave: all valid/ready outputs 0, payload outputs hold last value (don't care).
//   Reset (async, any time incl. mid-transaction): both FSMs to IDLE, all latches cleared,
//   every valid/ready output 0, m_arready/m_awready/m_wready 0 while rst high, 1 first cycle after release;
//   in-flight transaction dropped (slaves share rst).
// TESTING
//   - read 0x0200_0000, CLINT returns 0x0000_1234 -> s0_arvalid 1 cycle after AR fire, s1_arvalid never high, m_rdata=0x1234 resp=0
//   - read 0x8000_0000 -> routed to s1 only; read 0x0200_FFFC -> s0; 0x0201_0000 -> s1
//   - CLINT read with 15-cycle delay -> s0_araddr constant from AR fire to R fire; m_arready 0 throughout
//   - AW at cycle 0, W at cycle 3 to 0x0200_0000 -> s0_awvalid and s0_wvalid first high together at cycle 4; bresp forwarded
//   - m_rready low 5 cycles with s0_rvalid high -> m_rvalid held, m_rdata stable, s0_rready 0, no new AR accepted
//   - assert rst while in R_RESP and W_REQ -> all valids 0 immediately, after release m_arready=m_awready=m_wready=1

Source files
------------

// File: rtl/axi_clint_if.sv
`default_nettype none
// ============================================================================
// Module : axi_clint_if
// Brief  : AXI4 channel bundle (32-bit addr/data, 4-bit id) for the CLINT xbar
// Rev    : 1.0  initial release
// ============================================================================
interface axi_clint_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [3:0]  rid;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        wlast;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;

    modport master (
        output araddr, arvalid, arid, arlen, arsize, arburst, rready,
        output awaddr, awvalid, awid, awlen, awsize, awburst,
        output wdata, wstrb, wvalid, wlast, bready,
        input  arready, rdata, rresp, rvalid, rlast, rid,
        input  awready, wready, bresp, bvalid, bid
    );

    modport slave (
        input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
        input  awaddr, awvalid, awid, awlen, awsize, awburst,
        input  wdata, wstrb, wvalid, wlast, bready,
        output arready, rdata, rresp, rvalid, rlast, rid,
        output awready, wready, bresp, bvalid, bid
    );
endinterface
`default_nettype wire

// File: rtl/axi_clint_xbar.sv
`default_nettype none
// ============================================================================
// Module : axi_clint_xbar
// Brief  : 1-master/2-slave AXI4 router; CLINT window -> s0, all else -> s1
// Rev    : 1.0  initial release
// ============================================================================
module axi_clint_xbar #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_SIZE = 32'h0001_0000
) (
    input  wire logic         clk,
    input  wire logic         rst,
    axi_clint_if.slave        m,
    axi_clint_if.master       s0,
    axi_clint_if.master       s1
);
    localparam logic [31:0] c_MASK = ~(CLINT_SIZE - 32'd1);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_RESP = 2'd2} rstate_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2} wstate_t;

    rstate_t     r_rstate, w_rnext;
    wstate_t     r_wstate, w_wnext;
    logic [31:0] r_araddr, r_awaddr, r_wdata;
    logic [3:0]  r_arid, r_awid, r_wstrb;
    logic [7:0]  r_arlen, r_awlen;
    logic [2:0]  r_arsize, r_awsize;
    logic [1:0]  r_arburst, r_awburst;
    logic        r_wlast;
    // In W_IDLE these flag "channel captured"; in W_REQ they flag "handshake done downstream".
    logic        r_aw_flag, r_w_flag;

    logic w_rsel, w_wsel;
    logic w_ar_fire, w_sar_ready, w_sr_valid, w_sr_last;
    logic w_aw_fire, w_w_fire, w_saw_fire, w_sw_fire, w_sb_valid;

    assign w_rsel = ((r_araddr & c_MASK) != CLINT_BASE);
    assign w_wsel = ((r_awaddr & c_MASK) != CLINT_BASE);

    // ---------------- read path ----------------
    assign m.arready   = (r_rstate == R_IDLE) && !rst;
    assign w_ar_fire   = m.arvalid && m.arready;
    assign w_sar_ready = w_rsel ? s1.arready : s0.arready;
    assign w_sr_valid  = w_rsel ? s1.rvalid  : s0.rvalid;
    assign w_sr_last   = w_rsel ? s1.rlast   : s0.rlast;

    assign s0.arvalid = (r_rstate == R_REQ) && !w_rsel;
    assign s1.arvalid = (r_rstate == R_REQ) &&  w_rsel;
    assign s0.rready  = (r_rstate == R_RESP) && !w_rsel && m.rready;
    assign s1.rready  = (r_rstate == R_RESP) &&  w_rsel && m.rready;
    assign {s0.araddr, s0.arid, s0.arlen, s0.arsize, s0.arburst} =
           {r_araddr, r_arid, r_arlen, r_arsize, r_arburst};
    assign {s1.araddr, s1.arid, s1.arlen, s1.arsize, s1.arburst} =
           {r_araddr, r_arid, r_arlen, r_arsize, r_arburst};

    assign m.rvalid = (r_rstate == R_RESP) && w_sr_valid;
    assign m.rdata  = w_rsel ? s1.rdata : s0.rdata;
    assign m.rresp  = w_rsel ? s1.rresp : s0.rresp;
    assign m.rid    = w_rsel ? s1.rid   : s0.rid;
    assign m.rlast  = w_sr_last;

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_fire)   w_rnext = R_REQ;
            R_REQ:   if (w_sar_ready) w_rnext = R_RESP;
            R_RESP:  if (w_sr_valid && m.rready && w_sr_last) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_araddr  <= '0;
            r_arid    <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
        end else begin
            r_rstate <= w_rnext;
            if (w_ar_fire) begin
                r_araddr  <= m.araddr;
                r_arid    <= m.arid;
                r_arlen   <= m.arlen;
                r_arsize  <= m.arsize;
                r_arburst <= m.arburst;
            end
        end
    end

    // ---------------- write path ----------------
    assign m.awready  = (r_wstate == W_IDLE) && !r_aw_flag && !rst;
    assign m.wready   = (r_wstate == W_IDLE) && !r_w_flag  && !rst;
    assign w_aw_fire  = m.awvalid && m.awready;
    assign w_w_fire   = m.wvalid  && m.wready;
    assign w_saw_fire = (r_wstate == W_REQ) && !r_aw_flag && (w_wsel ? s1.awready : s0.awready);
    assign w_sw_fire  = (r_wstate == W_REQ) && !r_w_flag  && (w_wsel ? s1.wready  : s0.wready);
    assign w_sb_valid = w_wsel ? s1.bvalid : s0.bvalid;

    assign s0.awvalid = (r_wstate == W_REQ) && !w_wsel && !r_aw_flag;
    assign s1.awvalid = (r_wstate == W_REQ) &&  w_wsel && !r_aw_flag;
    assign s0.wvalid  = (r_wstate == W_REQ) && !w_wsel && !r_w_flag;
    assign s1.wvalid  = (r_wstate == W_REQ) &&  w_wsel && !r_w_flag;
    assign s0.bready  = (r_wstate == W_RESP) && !w_wsel && m.bready;
    assign s1.bready  = (r_wstate == W_RESP) &&  w_wsel && m.bready;
    assign {s0.awaddr, s0.awid, s0.awlen, s0.awsize, s0.awburst} =
           {r_awaddr, r_awid, r_awlen, r_awsize, r_awburst};
    assign {s1.awaddr, s1.awid, s1.awlen, s1.awsize, s1.awburst} =
           {r_awaddr, r_awid, r_awlen, r_awsize, r_awburst};
    assign {s0.wdata, s0.wstrb, s0.wlast} = {r_wdata, r_wstrb, r_wlast};
    assign {s1.wdata, s1.wstrb, s1.wlast} = {r_wdata, r_wstrb, r_wlast};

    assign m.bvalid = (r_wstate == W_RESP) && w_sb_valid;
    assign m.bresp  = w_wsel ? s1.bresp : s0.bresp;
    assign m.bid    = w_wsel ? s1.bid   : s0.bid;

    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            W_IDLE:  if ((r_aw_flag || w_aw_fire) && (r_w_flag || w_w_fire))   w_wnext = W_REQ;
            W_REQ:   if ((r_aw_flag || w_saw_fire) && (r_w_flag || w_sw_fire)) w_wnext = W_RESP;
            W_RESP:  if (w_sb_valid && m.bready) w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_aw_flag <= 1'b0;
            r_w_flag  <= 1'b0;
            r_awaddr  <= '0;
            r_awid    <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wlast   <= 1'b0;
        end else begin
            r_wstate <= w_wnext;
            if (w_wnext != r_wstate) begin
                r_aw_flag <= 1'b0;
                r_w_flag  <= 1'b0;
            end else if (r_wstate == W_IDLE) begin
                if (w_aw_fire) r_aw_flag <= 1'b1;
                if (w_w_fire)  r_w_flag  <= 1'b1;
            end else if (r_wstate == W_REQ) begin
                if (w_saw_fire) r_aw_flag <= 1'b1;
                if (w_sw_fire)  r_w_flag  <= 1'b1;
            end
            if (w_aw_fire) begin
                r_awaddr  <= m.awaddr;
                r_awid    <= m.awid;
                r_awlen   <= m.awlen;
                r_awsize  <= m.awsize;
                r_awburst <= m.awburst;
            end
            if (w_w_fire) begin
                r_wdata <= m.wdata;
                r_wstrb <= m.wstrb;
                r_wlast <= m.wlast;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi_clint_xbar.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_clint_xbar
// Brief  : directed scoreboard bench for axi_clint_xbar with two slave models
// Rev    : 1.0  initial release
// ============================================================================
module tb_axi_clint_xbar;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_clint_if m_if();
    axi_clint_if s0_if();
    axi_clint_if s1_if();

    axi_clint_xbar dut (.clk(clk), .rst(rst), .m(m_if), .s0(s0_if), .s1(s1_if));

    int n_chk = 0;
    int n_fail = 0;
    logic [38:0] rq[$];   // {data, resp, id, last}
    logic [5:0]  bq[$];   // {resp, id}

    int          rlat[2];
    logic [31:0] rbase[2];
    logic [1:0]  rresp_k[2];
    logic [1:0]  bresp_k[2];
    logic        awrdy[2];
    int          ar_cnt[2];
    int          aw_cnt[2];
    logic [31:0] wdata_seen[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int tb_sel(input logic [31:0] a);
        return (a >= 32'h0200_0000 && a <= 32'h0200_FFFF) ? 0 : 1;
    endfunction

    // ---------------- slave 0 model (CLINT) ----------------
    initial begin
        logic ar_f, r_f, aw_f, w_f, b_f, busy, gaw, gw;
        logic [7:0] len, nl;
        logic [3:0] id, ni, bidv, nbid;
        logic [31:0] nwd;
        int cnt, beat;
        {s0_if.arready, s0_if.rvalid, s0_if.rlast, s0_if.awready, s0_if.wready, s0_if.bvalid} = '0;
        {s0_if.rdata, s0_if.rresp, s0_if.rid, s0_if.bresp, s0_if.bid} = '0;
        {busy, gaw, gw, len, id, bidv, nl, ni, nbid, nwd} = '0;
        cnt = 0; beat = 0;
        forever begin
            @(negedge clk);
            ar_f = s0_if.arvalid && s0_if.arready;
            if (ar_f) begin nl = s0_if.arlen; ni = s0_if.arid; end
            r_f  = s0_if.rvalid && s0_if.rready;
            aw_f = s0_if.awvalid && s0_if.awready;
            if (aw_f) nbid = s0_if.awid;
            w_f  = s0_if.wvalid && s0_if.wready;
            if (w_f) nwd = s0_if.wdata;
            b_f  = s0_if.bvalid && s0_if.bready;
            @(posedge clk); #1;
            if (rst) begin
                {s0_if.arready, s0_if.rvalid, s0_if.rlast, s0_if.awready, s0_if.wready, s0_if.bvalid} = '0;
                {busy, gaw, gw} = '0;
            end else begin
                s0_if.arready = 1'b1;
                s0_if.wready  = 1'b1;
                s0_if.awready = awrdy[0];
                if (ar_f) begin
                    busy = 1'b1; cnt = rlat[0]; beat = 0; len = nl; id = ni; ar_cnt[0]++;
                end else if (r_f) begin
                    if (s0_if.rlast) begin busy = 1'b0; s0_if.rvalid = 1'b0; s0_if.rlast = 1'b0; end
                    else begin beat++; s0_if.rdata = rbase[0] + 32'(beat); s0_if.rlast = (beat == int'(len)); end
                end else if (busy && !s0_if.rvalid) begin
                    if (cnt == 0) begin
                        s0_if.rvalid = 1'b1; s0_if.rdata = rbase[0] + 32'(beat);
                        s0_if.rresp = rresp_k[0]; s0_if.rid = id; s0_if.rlast = (beat == int'(len));
                    end else cnt--;
                end
                if (b_f) begin s0_if.bvalid = 1'b0; gaw = 1'b0; gw = 1'b0; end
                if (aw_f) begin gaw = 1'b1; bidv = nbid; aw_cnt[0]++; end
                if (w_f) begin gw = 1'b1; wdata_seen[0] = nwd; end
                if (gaw && gw && !s0_if.bvalid) begin
                    s0_if.bvalid = 1'b1; s0_if.bresp = bresp_k[0]; s0_if.bid = bidv;
                end
            end
        end
    end

    // ---------------- slave 1 model (SoC) ----------------
    initial begin
        logic ar_f, r_f, aw_f, w_f, b_f, busy, gaw, gw;
        logic [7:0] len, nl;
        logic [3:0] id, ni, bidv, nbid;
        logic [31:0] nwd;
        int cnt, beat;
        {s1_if.arready, s1_if.rvalid, s1_if.rlast, s1_if.awready, s1_if.wready, s1_if.bvalid} = '0;
        {s1_if.rdata, s1_if.rresp, s1_if.rid, s1_if.bresp, s1_if.bid} = '0;
        {busy, gaw, gw, len, id, bidv, nl, ni, nbid, nwd} = '0;
        cnt = 0; beat = 0;
        forever begin
            @(negedge clk);
            ar_f = s1_if.arvalid && s1_if.arready;
            if (ar_f) begin nl = s1_if.arlen; ni = s1_if.arid; end
            r_f  = s1_if.rvalid && s1_if.rready;
            aw_f = s1_if.awvalid && s1_if.awready;
            if (aw_f) nbid = s1_if.awid;
            w_f  = s1_if.wvalid && s1_if.wready;
            if (w_f) nwd = s1_if.wdata;
            b_f  = s1_if.bvalid && s1_if.bready;
            @(posedge clk); #1;
            if (rst) begin
                {s1_if.arready, s1_if.rvalid, s1_if.rlast, s1_if.awready, s1_if.wready, s1_if.bvalid} = '0;
                {busy, gaw, gw} = '0;
            end else begin
                s1_if.arready = 1'b1;
                s1_if.wready  = 1'b1;
                s1_if.awready = awrdy[1];
                if (ar_f) begin
                    busy = 1'b1; cnt = rlat[1]; beat = 0; len = nl; id = ni; ar_cnt[1]++;
                end else if (r_f) begin
                    if (s1_if.rlast) begin busy = 1'b0; s1_if.rvalid = 1'b0; s1_if.rlast = 1'b0; end
                    else begin beat++; s1_if.rdata = rbase[1] + 32'(beat); s1_if.rlast = (beat == int'(len)); end
                end else if (busy && !s1_if.rvalid) begin
                    if (cnt == 0) begin
                        s1_if.rvalid = 1'b1; s1_if.rdata = rbase[1] + 32'(beat);
                        s1_if.rresp = rresp_k[1]; s1_if.rid = id; s1_if.rlast = (beat == int'(len));
                    end else cnt--;
                end
                if (b_f) begin s1_if.bvalid = 1'b0; gaw = 1'b0; gw = 1'b0; end
                if (aw_f) begin gaw = 1'b1; bidv = nbid; aw_cnt[1]++; end
                if (w_f) begin gw = 1'b1; wdata_seen[1] = nwd; end
                if (gaw && gw && !s1_if.bvalid) begin
                    s1_if.bvalid = 1'b1; s1_if.bresp = bresp_k[1]; s1_if.bid = bidv;
                end
            end
        end
    end

    // ---------------- upstream response monitor / scoreboard ----------------
    initial begin
        logic [38:0] er;
        logic [5:0]  eb;
        forever begin
            @(negedge clk);
            if (!rst && m_if.rvalid && m_if.rready) begin
                chk("r_beat_expected", 64'(rq.size() != 0), 64'd1);
                if (rq.size() != 0) begin
                    er = rq.pop_front();
                    chk("r_beat", 64'({m_if.rdata, m_if.rresp, m_if.rid, m_if.rlast}), 64'(er));
                end
            end
            if (!rst && m_if.bvalid && m_if.bready) begin
                chk("b_expected", 64'(bq.size() != 0), 64'd1);
                if (bq.size() != 0) begin
                    eb = bq.pop_front();
                    chk("b_resp", 64'({m_if.bresp, m_if.bid}), 64'(eb));
                end
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        int s;
        logic ok;
        s = tb_sel(a);
        ok = 1'b0;
        for (int b = 0; b <= int'(len); b++)
            rq.push_back({rbase[s] + 32'(b), rresp_k[s], id, (b == int'(len))});
        @(posedge clk); #1;
        m_if.araddr = a; m_if.arid = id; m_if.arlen = len;
        m_if.arsize = 3'd2; m_if.arburst = 2'b01; m_if.arvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = m_if.arready;
        end
        chk("ar_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        m_if.arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [31:0] d);
        logic aw_ok, w_ok;
        bq.push_back({bresp_k[tb_sel(a)], id});
        @(posedge clk); #1;
        m_if.awaddr = a; m_if.awid = id; m_if.awlen = 8'd0; m_if.awsize = 3'd2;
        m_if.awburst = 2'b01; m_if.awvalid = 1'b1;
        m_if.wdata = d; m_if.wstrb = 4'hF; m_if.wlast = 1'b1; m_if.wvalid = 1'b1;
        for (int i = 0; i < 50 && (m_if.awvalid || m_if.wvalid); i++) begin
            @(negedge clk);
            aw_ok = m_if.awvalid && m_if.awready;
            w_ok  = m_if.wvalid && m_if.wready;
            @(posedge clk); #1;
            if (aw_ok) m_if.awvalid = 1'b0;
            if (w_ok)  m_if.wvalid  = 1'b0;
        end
        chk("aw_w_accept", 64'({m_if.awvalid, m_if.wvalid}), 64'd0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && (rq.size() != 0 || bq.size() != 0); i++) @(negedge clk);
        chk("r_drain", 64'(rq.size()), 64'd0);
        chk("b_drain", 64'(bq.size()), 64'd0);
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        logic [31:0] addrs[4];
        rst = 1'b1;
        {m_if.araddr, m_if.arid, m_if.arlen, m_if.arsize, m_if.arburst, m_if.arvalid} = '0;
        {m_if.awaddr, m_if.awid, m_if.awlen, m_if.awsize, m_if.awburst, m_if.awvalid} = '0;
        {m_if.wdata, m_if.wstrb, m_if.wlast, m_if.wvalid} = '0;
        m_if.rready = 1'b1; m_if.bready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rlat[k] = 0; rresp_k[k] = 2'b00; bresp_k[k] = 2'b00; awrdy[k] = 1'b1;
            ar_cnt[k] = 0; aw_cnt[k] = 0; wdata_seen[k] = '0;
        end
        rbase[0] = 32'h0000_1234; rbase[1] = 32'hA5A5_0000;

        repeat (2) @(negedge clk);
        chk("rst_arready", 64'(m_if.arready), 64'd0);
        chk("rst_awready", 64'(m_if.awready), 64'd0);
        chk("rst_wready",  64'(m_if.wready), 64'd0);
        chk("rst_valids",  64'({m_if.rvalid, m_if.bvalid, s0_if.arvalid, s1_if.arvalid}), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_readies", 64'({m_if.arready, m_if.awready, m_if.wready}), 64'b111);

        // CLINT read: one-cycle latency to s0, s1 untouched
        c0 = ar_cnt[0]; c1 = ar_cnt[1];
        do_read(32'h0200_0000, 4'd3, 8'd0);
        @(negedge clk);
        chk("s0_arvalid_lat", 64'(s0_if.arvalid), 64'd1);
        chk("s1_arvalid_off", 64'(s1_if.arvalid), 64'd0);
        wait_drain();
        chk("t1_s0_count", 64'(ar_cnt[0] - c0), 64'd1);
        chk("t1_s1_count", 64'(ar_cnt[1] - c1), 64'd0);

        // address decode boundaries
        addrs[0] = 32'h8000_0000; addrs[1] = 32'h0200_FFFC;
        addrs[2] = 32'h0201_0000; addrs[3] = 32'h01FF_FFFC;
        for (int k = 0; k < 4; k++) begin
            c0 = ar_cnt[0]; c1 = ar_cnt[1];
            do_read(addrs[k], 4'(k + 1), 8'd0);
            wait_drain();
            chk("route_s0", 64'(ar_cnt[0] - c0), 64'(tb_sel(addrs[k]) == 0));
            chk("route_s1", 64'(ar_cnt[1] - c1), 64'(tb_sel(addrs[k]) == 1));
        end

        // burst from SoC, SLVERR from CLINT
        do_read(32'h8000_0010, 4'd5, 8'd3);
        wait_drain();
        rresp_k[0] = 2'b10;
        do_read(32'h0200_0008, 4'd6, 8'd0);
        wait_drain();
        rresp_k[0] = 2'b00;

        // slow CLINT: latched address held, no new AR accepted
        rlat[0] = 15;
        do_read(32'h0200_4000, 4'd2, 8'd0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("hold_araddr", 64'(s0_if.araddr), 64'h0200_4000);
            chk("hold_arready", 64'(m_if.arready), 64'd0);
            if (m_if.rvalid && m_if.rready) break;
        end
        wait_drain();
        rlat[0] = 0;

        // upstream backpressure on R
        @(posedge clk); #1; m_if.rready = 1'b0;
        do_read(32'h0200_0020, 4'd7, 8'd0);
        for (int i = 0; i < 20 && !s0_if.rvalid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid", 64'(m_if.rvalid), 64'd1);
            chk("bp_rdata", 64'(m_if.rdata), 64'h0000_1234);
            chk("bp_s0_rready", 64'(s0_if.rready), 64'd0);
            chk("bp_arready", 64'(m_if.arready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1; m_if.rready = 1'b1;
        wait_drain();

        // AW at cycle 0, W at cycle 3: both presented to CLINT together at cycle 4
        bresp_k[0] = 2'b10;
        bq.push_back({2'b10, 4'd9});
        @(posedge clk); #1;
        m_if.awaddr = 32'h0200_0000; m_if.awid = 4'd9; m_if.awlen = 8'd0;
        m_if.awsize = 3'd2; m_if.awburst = 2'b01; m_if.awvalid = 1'b1;
        @(negedge clk); chk("w0_awready", 64'(m_if.awready), 64'd1);
        @(posedge clk); #1; m_if.awvalid = 1'b0;
        @(negedge clk);
        chk("w1_awready", 64'(m_if.awready), 64'd0);
        chk("w1_wready", 64'(m_if.wready), 64'd1);
        chk("w1_s0_valids", 64'({s0_if.awvalid, s0_if.wvalid}), 64'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("w2_s0_valids", 64'({s0_if.awvalid, s0_if.wvalid}), 64'd0);
        @(posedge clk); #1;
        m_if.wdata = 32'hDEAD_BEEF; m_if.wstrb = 4'hF; m_if.wlast = 1'b1; m_if.wvalid = 1'b1;
        @(negedge clk); chk("w3_s0_valids", 64'({s0_if.awvalid, s0_if.wvalid}), 64'd0);
        @(posedge clk); #1; m_if.wvalid = 1'b0;
        @(negedge clk); chk("w4_s0_valids", 64'({s0_if.awvalid, s0_if.wvalid}), 64'b11);
        wait_drain();
        chk("w_s0_data", 64'(wdata_seen[0]), 64'hDEAD_BEEF);
        bresp_k[0] = 2'b00;

        // concurrent read from CLINT and write to SoC
        rlat[0] = 5;
        do_read(32'h0200_0040, 4'd1, 8'd0);
        do_write(32'h8000_1000, 4'd4, 32'h1357_9BDF);
        wait_drain();
        chk("w_s1_data", 64'(wdata_seen[1]), 64'h1357_9BDF);
        rlat[0] = 0;

        // async reset with read in R_RESP and write stuck in W_REQ
        rlat[1] = 20; awrdy[1] = 1'b0;
        do_read(32'h8000_0080, 4'd2, 8'd0);
        do_write(32'h8000_0100, 4'd4, 32'hCAFE_F00D);
        @(negedge clk);
        chk("pre_rst_awvalid", 64'(s1_if.awvalid), 64'd1);
        chk("pre_rst_arready", 64'(m_if.arready), 64'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_m_valids", 64'({m_if.rvalid, m_if.bvalid}), 64'd0);
        chk("rst_mid_s1_valids", 64'({s1_if.arvalid, s1_if.awvalid, s1_if.wvalid}), 64'd0);
        chk("rst_mid_s1_readies", 64'({s1_if.rready, s1_if.bready}), 64'd0);
        chk("rst_mid_m_readies", 64'({m_if.arready, m_if.awready, m_if.wready}), 64'd0);
        rq.delete(); bq.delete();
        awrdy[1] = 1'b1; rlat[1] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_readies", 64'({m_if.arready, m_if.awready, m_if.wready}), 64'b111);

        // recovery
        do_read(32'h8000_0040, 4'd8, 8'd1);
        do_write(32'h0200_0010, 4'd3, 32'h0BAD_F00D);
        wait_drain();
        chk("rec_s0_data", 64'(wdata_seen[0]), 64'h0BAD_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
